// File: rtl/rdft_add_sched.sv
// rdft_add_sched: round-robin scheduler sharing one registered complex adder among N requesters.
// Optional macro RDFT_SAT_EN: each lane saturates instead of wrapping on overflow.
module rdft_add_sched #(
    parameter int W  = 32,
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req_valid,
    output logic [N-1:0]    req_ready,
    input  logic [N*W-1:0]  req_a,
    input  logic [N*W-1:0]  req_ja,
    input  logic [N*W-1:0]  req_b,
    input  logic [N*W-1:0]  req_jb,
    output logic            res_valid,
    input  logic            res_ready,
    output logic [W-1:0]    res_s,
    output logic [W-1:0]    res_js,
    output logic [IW-1:0]   res_id
);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [IW-1:0] r_rr_ptr;
    logic [W-1:0]  r_s;
    logic [W-1:0]  r_js;
    logic [IW-1:0] r_id;

    logic          w_grant_vld;
    logic [IW-1:0] w_grant_idx;
    logic [N-1:0]  w_grant;
    logic          w_slot_free;
    logic          w_accept;
    logic [IW-1:0] w_rr_nxt;
    logic [W-1:0]  w_sum_s;
    logic [W-1:0]  w_sum_js;

    logic [W-1:0]  w_a_arr  [N];
    logic [W-1:0]  w_ja_arr [N];
    logic [W-1:0]  w_b_arr  [N];
    logic [W-1:0]  w_jb_arr [N];

    // One lane of the adder; carry out is dropped unless saturation is built in.
    function automatic logic [W-1:0] lane_add(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef RDFT_SAT_EN
        logic [W:0] sum;
        sum = {a[W-1], a} + {b[W-1], b};
        if (sum[W] != sum[W-1]) begin
            lane_add = sum[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end else begin
            lane_add = sum[W-1:0];
        end
`else
        lane_add = a + b;
`endif
    endfunction

    // Unpack the flattened operand buses into per-requester lanes.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            w_a_arr[i]  = req_a[i*W +: W];
            w_ja_arr[i] = req_ja[i*W +: W];
            w_b_arr[i]  = req_b[i*W +: W];
            w_jb_arr[i] = req_jb[i*W +: W];
        end
    end

    // Round-robin search: first valid requester at or above rr_ptr, wrapping at N.
    always_comb begin
        logic [IW:0] cand;
        w_grant_vld = 1'b0;
        w_grant_idx = '0;
        cand        = '0;
        for (int k = 0; k < N; k++) begin
            cand = {1'b0, r_rr_ptr} + (IW+1)'(k);
            if (cand >= (IW+1)'(N)) begin
                cand = cand - (IW+1)'(N);
            end else begin
                cand = cand;
            end
            if (!w_grant_vld && req_valid[cand[IW-1:0]]) begin
                w_grant_vld = 1'b1;
                w_grant_idx = cand[IW-1:0];
            end else begin
                w_grant_vld = w_grant_vld;
            end
        end
    end

    // One-hot grant and handshake; ready is held low while reset is asserted.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            w_grant[i] = w_grant_vld && (w_grant_idx == IW'(i));
        end
        w_slot_free = (r_state == ST_EMPTY) || res_ready;
        req_ready   = w_grant & {N{w_slot_free & rst}};
        w_accept    = |req_ready;
        if (w_grant_idx == IW'(N-1)) begin
            w_rr_nxt = '0;
        end else begin
            w_rr_nxt = w_grant_idx + IW'(1);
        end
        w_sum_s  = lane_add(w_a_arr[w_grant_idx],  w_b_arr[w_grant_idx]);
        w_sum_js = lane_add(w_ja_arr[w_grant_idx], w_jb_arr[w_grant_idx]);
    end

    // Output-register occupancy: accept fills, drain without accept empties.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_EMPTY: begin
                if (w_accept) begin
                    w_state_nxt = ST_FULL;
                end else begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (w_accept) begin
                    w_state_nxt = ST_FULL;
                end else if (res_ready) begin
                    w_state_nxt = ST_EMPTY;
                end else begin
                    w_state_nxt = ST_FULL;
                end
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Result payload and pointer; both change only on accept so data holds under backpressure.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s      <= '0;
            r_js     <= '0;
            r_id     <= '0;
            r_rr_ptr <= '0;
        end else if (w_accept) begin
            r_s      <= w_sum_s;
            r_js     <= w_sum_js;
            r_id     <= w_grant_idx;
            r_rr_ptr <= w_rr_nxt;
        end
    end

    assign res_valid = (r_state == ST_FULL);
    assign res_s     = r_s;
    assign res_js    = r_js;
    assign res_id    = r_id;

endmodule

// File: tb/tb_rdft_add_sched.sv
// Directed self-checking bench for rdft_add_sched (W=32, N=4); honours RDFT_SAT_EN for overflow expectations.
module tb_rdft_add_sched;

    localparam int W  = 32;
    localparam int N  = 4;
    localparam int IW = 2;

    logic            clk;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*W-1:0]  req_a;
    logic [N*W-1:0]  req_ja;
    logic [N*W-1:0]  req_b;
    logic [N*W-1:0]  req_jb;
    logic            res_valid;
    logic            res_ready;
    logic [W-1:0]    res_s;
    logic [W-1:0]    res_js;
    logic [IW-1:0]   res_id;

    int tests;
    int fails;

    rdft_add_sched #(.W(W), .N(N), .IW(IW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_ja    (req_ja),
        .req_b     (req_b),
        .req_jb    (req_jb),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_s     (res_s),
        .res_js    (res_js),
        .res_id    (res_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] ja,
                          input logic [W-1:0] b, input logic [W-1:0] jb);
        req_a[i*W +: W]  = a;
        req_ja[i*W +: W] = ja;
        req_b[i*W +: W]  = b;
        req_jb[i*W +: W] = jb;
    endtask

    task automatic check_res(input string tag, input logic [IW-1:0] id,
                             input logic [W-1:0] s, input logic [W-1:0] js);
        check({tag, "_valid"}, {63'd0, res_valid}, 64'd1);
        check({tag, "_id"},    {62'd0, res_id},    {62'd0, id});
        check({tag, "_s"},     {32'd0, res_s},     {32'd0, s});
        check({tag, "_js"},    {32'd0, res_js},    {32'd0, js});
    endtask

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        logic [W-1:0] exp_s;
        logic [W-1:0] exp_js;
        tests     = 0;
        fails     = 0;
        rst       = 1'b0;
        req_valid = 4'b1111;
        res_ready = 1'b0;
        req_a     = '0;
        req_ja    = '0;
        req_b     = '0;
        req_jb    = '0;

        // Reset state, with requests pending.
        #2;
        check("rst_valid", {63'd0, res_valid}, 64'd0);
        check("rst_s", {32'd0, res_s}, 64'd0);
        check("rst_js", {32'd0, res_js}, 64'd0);
        check("rst_id", {62'd0, res_id}, 64'd0);
        check("rst_ready", {60'd0, req_ready}, 64'd0);
        tick();

        // Single request from requester 2.
        rst       = 1'b1;
        req_valid = 4'b0100;
        res_ready = 1'b1;
        set_op(2, 32'd5, -32'sd3, 32'd7, 32'd10);
        #1;
        check("single_ready", {60'd0, req_ready}, 64'h4);
        tick();
        check_res("single", 2'd2, 32'd12, 32'd7);
        req_valid = 4'b0000;
        tick();
        check("drain_valid", {63'd0, res_valid}, 64'd0);

        // Round-robin with all requesters valid; pointer sits at 3.
        for (int i = 0; i < N; i++) begin
            set_op(i, 32'(i * 10), 32'(i), 32'd1, 32'd100);
        end
        req_valid = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            tick();
            check_res($sformatf("rr%0d", k), 2'((3 + k) % 4), 32'(((3 + k) % 4) * 10 + 1),
                      32'(((3 + k) % 4) + 100));
        end

        // Backpressure: result from requester 0 held, requesters 1 and 3 waiting.
        res_ready = 1'b0;
        req_valid = 4'b1010;
        #1;
        check("bp_ready", {60'd0, req_ready}, 64'd0);
        for (int k = 0; k < 5; k++) begin
            tick();
            check_res($sformatf("bp%0d", k), 2'd0, 32'd1, 32'd100);
            check($sformatf("bp%0d_ready", k), {60'd0, req_ready}, 64'd0);
        end
        res_ready = 1'b1;
        #1;
        check("bp_release_ready", {60'd0, req_ready}, 64'h2);
        tick();
        check_res("bp_after1", 2'd1, 32'd11, 32'd101);
        req_valid = 4'b1000;
        tick();
        check_res("bp_after3", 2'd3, 32'd31, 32'd103);

        // Skip idle: move pointer to 1, then 0 and 2 valid.
        req_valid = 4'b0001;
        tick();
        check_res("skip_pre", 2'd0, 32'd1, 32'd100);
        req_valid = 4'b0101;
        #1;
        check("skip_ready", {60'd0, req_ready}, 64'h4);
        tick();
        check_res("skip_first", 2'd2, 32'd21, 32'd102);
        req_valid = 4'b0001;
        tick();
        check_res("skip_second", 2'd0, 32'd1, 32'd100);

        // Overflow on both lanes, opposite directions.
        set_op(1, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0001, 32'hFFFF_FFFF);
        req_valid = 4'b0010;
        tick();
`ifdef RDFT_SAT_EN
        exp_s  = 32'h7FFF_FFFF;
        exp_js = 32'h8000_0000;
`else
        exp_s  = 32'h8000_0000;
        exp_js = 32'h7FFF_FFFF;
`endif
        check_res("ovf", 2'd1, exp_s, exp_js);

        // Reset mid-operation, between edges.
        req_valid = 4'b0000;
        res_ready = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        check("mid_rst_valid", {63'd0, res_valid}, 64'd0);
        check("mid_rst_s", {32'd0, res_s}, 64'd0);
        check("mid_rst_js", {32'd0, res_js}, 64'd0);
        check("mid_rst_id", {62'd0, res_id}, 64'd0);
        #2;
        rst = 1'b1;
        set_op(3, 32'd100, 32'd1, -32'sd50, 32'd2);
        req_valid = 4'b1000;
        #1;
        check("post_rst_ready", {60'd0, req_ready}, 64'h8);
        tick();
        check_res("post_rst", 2'd3, 32'd50, 32'd3);
        req_valid = 4'b0000;
        res_ready = 1'b1;
        tick();
        check("final_drain", {63'd0, res_valid}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
